// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin packet/burst arbiter that shares the async FIFO's single
//   write port among NUM_REQ requesters in the wclk domain. Each grant lasts
//   until the owner's last beat or MAX_BURST accepted beats, whichever comes
//   first. Every beat is gated by fifo_full, so a beat is never lost or
//   dropped.
//
// Ports
//   wclk, wrst_n           write clock, async active-low reset
//   req_valid/last/data    per-requester beat stream (slice i = requester i)
//   req_ready              per-requester accept; only the owner can be ready
//   fifo_full              registered full flag from write-pointer handler
//   w_en, wdata            FIFO write port (same-cycle mux of owner's beat)
//   grant_id, busy         current owner, valid while busy

module fifo_wr_arbiter_lane (
  input  logic sel_i,
  input  logic busy_i,
  input  logic full_i,
  output logic ready_o
);
  assign ready_o = busy_i & sel_i & ~full_i;
endmodule

module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          w_en,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q,  last_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  logic [NUM_REQ-1:0] sel;
  logic               g_valid, g_last;
  logic [GW-1:0]      pick;
  logic               found;

  // Owner decode: one-hot select plus the owner's valid/last/data.
  always_comb begin
    sel     = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    wdata   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GW'(i)) begin
        sel[i]  = 1'b1;
        g_valid = req_valid[i];
        g_last  = req_last[i];
        wdata   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign busy     = (state_q == GRANT);
  assign w_en     = busy & g_valid & ~fifo_full;
  assign grant_id = grant_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    fifo_wr_arbiter_lane u_lane (
      .sel_i   (sel[i]),
      .busy_i  (busy),
      .full_i  (fifo_full),
      .ready_o (req_ready[i])
    );
  end

  // Round-robin pick: lowest valid index above last_q first, then wrap to
  // the lowest valid index at or below last_q.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req_valid[j] && (GW'(j) > last_q)) begin
        found = 1'b1;
        pick  = GW'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req_valid[j] && (GW'(j) <= last_q)) begin
        found = 1'b1;
        pick  = GW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Stalls (owner not valid or FIFO full) leave everything untouched.
        if (w_en) begin
          if (g_last || (cnt_q == CW'(MAX_BURST - 1))) begin
            last_d  = grant_q;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic        fifo_full, w_en, busy;
  logic [7:0]  wdata;
  logic [1:0]  grant_id;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .w_en      (w_en),
    .wdata     (wdata),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge wclk);
    #1;
  endtask

  // Single requester `id` sends an nbeats packet (data base+b, last on the
  // final beat). Per-cycle expected w_en/busy and fifo_full drive are given
  // as bit patterns, cycle 0 in the MSB.
  task automatic run_pkt(input int id, input int nbeats, input int ncyc,
                         input logic [31:0] wen_p, input logic [31:0] busy_p,
                         input logic [31:0] full_p, input logic [7:0] base);
    int  b;
    logic hs;
    b = 0;
    for (int c = 0; c < ncyc; c++) begin
      req_valid = '0;
      req_last  = '0;
      if (b < nbeats) begin
        req_valid[id] = 1'b1;
        req_last[id]  = (b == nbeats - 1);
        req_data[id*8 +: 8] = base + 8'(b);
      end
      fifo_full = full_p[ncyc-1-c];
      @(negedge wclk);
      chk("pkt_wen",   32'(w_en),          32'(wen_p[ncyc-1-c]));
      chk("pkt_busy",  32'(busy),          32'(busy_p[ncyc-1-c]));
      chk("pkt_ready", 32'(req_ready[id]), 32'(wen_p[ncyc-1-c]));
      if (busy_p[ncyc-1-c]) chk("pkt_gid", 32'(grant_id), 32'(id));
      if (wen_p[ncyc-1-c])  chk("pkt_data", 32'(wdata), 32'(base + 8'(b)));
      hs = req_valid[id] & req_ready[id];
      step();
      if (hs) b++;
    end
    chk("pkt_beats", 32'(b), 32'(nbeats));
    req_valid = '0;
    req_last  = '0;
    fifo_full = 1'b0;
  endtask

  initial begin
    wrst_n    = 1'b0;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    fifo_full = 1'b0;

    // Reset state, with requests pending.
    repeat (2) @(negedge wclk);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_wen",   32'(w_en),      32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_gid",   32'(grant_id),  32'd0);
    step();
    wrst_n = 1'b1;

    // 1: all requesters, single-beat packets -> 0,1,2,3,0 with bubbles.
    for (int k = 0; k < 5; k++) begin
      @(negedge wclk);
      chk("rr_idle_wen",  32'(w_en), 32'd0);
      chk("rr_idle_busy", 32'(busy), 32'd0);
      step();
      @(negedge wclk);
      chk("rr_gid",   32'(grant_id),  32'(k % 4));
      chk("rr_wen",   32'(w_en),      32'd1);
      chk("rr_data",  32'(wdata),     32'(8'hA0 + 8'(k % 4)));
      chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      step();
    end
    req_valid = '0;
    req_last  = '0;

    // 2: req 2 ten-beat packet -> bursts 4,4,2.
    run_pkt(2, 10, 14, 32'b01111011110110, 32'b01111011110110, 32'b0, 8'h10);

    // 3: req 0 four-beat packet, full for 3 cycles mid-burst.
    run_pkt(0, 4, 9, 32'b011000110, 32'b011111110, 32'b000111000, 8'h40);

    // 4: req 1 owns; req 3 and req 0 wait; next grant goes to 3, then 0.
    req_data  = {8'h33, 8'h22, 8'h11, 8'hC0};
    req_valid = 4'b0010;
    @(negedge wclk);
    chk("own_idle", 32'(busy), 32'd0);
    step();
    req_valid = 4'b1011;
    req_last  = 4'b1001;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) req_last = 4'b1011;
      @(negedge wclk);
      chk("own_gid",   32'(grant_id),  32'd1);
      chk("own_ready", 32'(req_ready), 32'b0010);
      chk("own_data",  32'(wdata),     32'h11);
      step();
    end
    req_valid = 4'b1001;
    @(negedge wclk);
    chk("own_bubble", 32'(busy), 32'd0);
    step();
    @(negedge wclk);
    chk("own_next_gid",  32'(grant_id), 32'd3);
    chk("own_next_data", 32'(wdata),    32'h33);
    step();
    req_valid = 4'b0001;
    step();
    @(negedge wclk);
    chk("own_then0", 32'(grant_id), 32'd0);
    chk("own_then0_wen", 32'(w_en), 32'd1);
    step();
    req_valid = '0;
    req_last  = '0;

    // 5: reset mid-burst.
    req_valid = 4'b0100;
    step();
    @(negedge wclk);
    chk("mrst_pre_gid", 32'(grant_id), 32'd2);
    step();
    chk("mrst_beat2_wen", 32'(w_en), 32'd1);
    wrst_n = 1'b0;
    #1;
    chk("mrst_wen",   32'(w_en),      32'd0);
    chk("mrst_busy",  32'(busy),      32'd0);
    chk("mrst_ready", 32'(req_ready), 32'd0);
    chk("mrst_gid",   32'(grant_id),  32'd0);
    step();
    wrst_n    = 1'b1;
    req_valid = 4'b0101;
    @(negedge wclk);
    chk("mrst_idle", 32'(busy), 32'd0);
    step();
    @(negedge wclk);
    chk("mrst_prio_gid", 32'(grant_id), 32'd0);
    chk("mrst_prio_data", 32'(wdata),   32'hC0);
    step();
    req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
